// File: rtl/vblank_update_scheduler.sv
// Per-frame round-robin req/grant/done scheduler for the vertical-blanking update window.
// Define SCHED_TIMEOUT_EN to build the per-grant watchdog; otherwise oTimeout is always 0.
module vblank_update_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               startOfFrame,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oTimeout,
  output logic [7:0]         oOverrunCnt
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, FINISH} state_t;

  state_t             state;
  logic               sof_q;
  logic               sof_edge;
  logic [NUM_REQ-1:0] pending;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   start_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic               found;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               done_hit;
  logic               wd_expired;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("vblank_update_scheduler: illegal parameter combination");
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  assign sof_edge = startOfFrame & ~sof_q;

  // grant is onehot(cur_idx) throughout GRANT, so masking done with it picks done[idx]
  assign done_hit = |(done & grant);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = ptr;
    found   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && cand == IDX_W'(j) && pending[j]) begin
          found   = 1'b1;
          sel_idx = cand;
        end
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_onehot[j] = (sel_idx == IDX_W'(j));
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wd_cnt;

  // Held at zero outside GRANT, so it restarts from zero on every new grant
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wd_cnt <= '0;
    end else if (state != GRANT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // A new frame edge outside IDLE overrides everything and restarts the frame
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= IDLE;
      sof_q       <= 1'b0;
      pending     <= '0;
      ptr         <= '0;
      start_ptr   <= '0;
      cur_idx     <= '0;
      grant       <= '0;
      oTimeout    <= 1'b0;
      oOverrunCnt <= 8'd0;
    end else begin
      sof_q    <= startOfFrame;
      oTimeout <= 1'b0;
      if (sof_edge && state != IDLE) begin
        if (oOverrunCnt != 8'hFF) begin
          oOverrunCnt <= oOverrunCnt + 8'd1;
        end
        grant   <= '0;
        pending <= req;
        ptr     <= start_ptr;
        state   <= SCAN;
      end else begin
        case (state)
          IDLE: begin
            if (sof_edge) begin
              pending <= req;
              ptr     <= start_ptr;
              state   <= SCAN;
            end
          end
          SCAN: begin
            if (!found) begin
              state <= FINISH;
            end else begin
              grant   <= sel_onehot;
              cur_idx <= sel_idx;
              state   <= GRANT;
            end
          end
          GRANT: begin
            if (done_hit || wd_expired) begin
              pending  <= pending & ~grant;
              ptr      <= wrap_inc(cur_idx);
              grant    <= '0;
              oTimeout <= ~done_hit;
              state    <= SCAN;
            end
          end
          FINISH: begin
            start_ptr <= wrap_inc(start_ptr);
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign oBusy      = (state != IDLE);
  assign oFrameDone = (state == FINISH) && !sof_edge;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Testbench for vblank_update_scheduler: expected grant sequence per frame is queued
// from a round-robin model when the frame starts and popped as grants appear.
`timescale 1ns/1ps
module tb_vblank_update_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int WAIT_MAX = 40;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic       startOfFrame;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       oBusy;
  logic       oFrameDone;
  logic       oTimeout;
  logic [7:0] oOverrunCnt;

  int         compared   = 0;
  int         mismatched = 0;
  logic [3:0] exp_q[$];
  int         model_sp   = 0;
  int         model_ovr  = 0;

  vblank_update_scheduler #(
    .NUM_REQ(4),
    .IDX_W(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n(iRST_n),
    .startOfFrame(startOfFrame),
    .req(req),
    .done(done),
    .grant(grant),
    .oBusy(oBusy),
    .oFrameDone(oFrameDone),
    .oTimeout(oTimeout),
    .oOverrunCnt(oOverrunCnt)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iVGA_CLK);
  endtask

  // Raise startOfFrame for one cycle; returns at the first cycle after the edge
  task automatic applyStimulus(input logic [3:0] req_val);
    req          = req_val;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic pushExpected(input logic [3:0] req_val);
    logic [3:0] one;
    int         idx;
    one = 4'b0001;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (model_sp + k) % NUM_REQ;
      if (req_val[idx]) exp_q.push_back(one << idx);
    end
  endtask

  task automatic serveGrants(input logic [3:0] stray, input logic [3:0] late);
    int         waits;
    logic [3:0] expg;
    bit         first;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      expg  = exp_q.pop_front();
      waits = 0;
      while (grant == 4'b0000 && waits < WAIT_MAX) begin
        tick();
        waits++;
      end
      checkOutput("grant_gap", waits, 1);
      checkOutput("grant", grant, expg);
      done = stray;
      tick();
      if (first) begin
        req   = req | late;
        first = 1'b0;
      end
      if (stray != 4'b0000) checkOutput("stray_done_ignored", grant, expg);
      done = expg;
      tick();
      done = 4'b0000;
    end
  endtask

  task automatic finishFrame();
    int waits;
    waits = 0;
    while (!oFrameDone && waits < WAIT_MAX) begin
      tick();
      waits++;
    end
    checkOutput("fdone_latency", waits, 1);
    checkOutput("fdone", oFrameDone, 1);
    tick();
    checkOutput("busy_fall", oBusy, 0);
    checkOutput("fdone_one_cycle", oFrameDone, 0);
    model_sp = (model_sp + 1) % NUM_REQ;
    req      = 4'b0000;
  endtask

  task automatic runFrame(input logic [3:0] req_val, input logic [3:0] stray, input logic [3:0] late);
    pushExpected(req_val);
    applyStimulus(req_val);
    checkOutput("busy_rise", oBusy, 1);
    serveGrants(stray, late);
    finishFrame();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] stopping");
  end

  initial begin
    int tmo_seen;
    iRST_n       = 1'b0;
    startOfFrame = 1'b0;
    req          = 4'b0000;
    done         = 4'b0000;
    tick();
    tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_busy", oBusy, 0);
    checkOutput("rst_fdone", oFrameDone, 0);
    checkOutput("rst_timeout", oTimeout, 0);
    checkOutput("rst_ovr", oOverrunCnt, 0);
    iRST_n = 1'b1;
    tick();

    // Rotation: three full frames starting at 0, 1, 2
    runFrame(4'b1111, 4'b0000, 4'b0000);
    runFrame(4'b1111, 4'b0000, 4'b0000);
    runFrame(4'b1111, 4'b0000, 4'b0000);

    // Empty frame brings start_ptr back to 0
    runFrame(4'b0000, 4'b0000, 4'b0000);
    checkOutput("empty_ovr", oOverrunCnt, 0);

    // Sparse requests with stray done[0] and a late req[2]
    runFrame(4'b1010, 4'b0001, 4'b0100);

    // Overrun while the second grant is held; restart uses the same start_ptr
    applyStimulus(4'b1111);
    tick();
    checkOutput("ovr_first_grant", grant, 4'b0010);
    done = 4'b0010;
    tick();
    done = 4'b0000;
    tick();
    checkOutput("ovr_second_grant", grant, 4'b0100);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    model_ovr    = 1;
    checkOutput("ovr_cnt_grant", oOverrunCnt, model_ovr);
    checkOutput("ovr_grant_clear", grant, 0);
    checkOutput("ovr_busy", oBusy, 1);
    pushExpected(4'b1111);
    serveGrants(4'b0000, 4'b0000);
    finishFrame();

    // Edge landing on FINISH
    applyStimulus(4'b0000);
    tick();
    checkOutput("fin_pre_fdone", oFrameDone, 1);
    startOfFrame = 1'b1;
    #1;
    checkOutput("fin_edge_no_fdone", oFrameDone, 0);
    tick();
    startOfFrame = 1'b0;
    model_ovr    = 2;
    checkOutput("fin_edge_ovr", oOverrunCnt, model_ovr);
    checkOutput("fin_edge_busy", oBusy, 1);
    finishFrame();

    // 300 consecutive overruns saturate the counter
    applyStimulus(4'b0000);
    for (int i = 0; i < 300; i++) begin
      tick();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (model_ovr < 255) model_ovr++;
    end
    checkOutput("ovr_saturate", oOverrunCnt, model_ovr);
    finishFrame();

    // Watchdog behaviour on a grant that never completes
    applyStimulus(4'b1100);
    tick();
    checkOutput("wd_grant2", grant, 4'b0100);
`ifdef SCHED_TIMEOUT_EN
    repeat (15) tick();
    checkOutput("wd_still_held", grant, 4'b0100);
    tick();
    checkOutput("wd_revoked", grant, 0);
    checkOutput("wd_timeout_pulse", oTimeout, 1);
    tick();
    checkOutput("wd_timeout_single", oTimeout, 0);
    tick();
    checkOutput("wd_next_grant", grant, 4'b1000);
    repeat (15) tick();
    done = 4'b1000;
    tick();
    done = 4'b0000;
    checkOutput("wd_done_wins_grant", grant, 0);
    checkOutput("wd_done_wins_tmo", oTimeout, 0);
    finishFrame();
`else
    tmo_seen = 0;
    repeat (20) begin
      tick();
      if (oTimeout) tmo_seen++;
    end
    checkOutput("nowd_hold", grant, 4'b0100);
    checkOutput("nowd_no_timeout", tmo_seen, 0);
    req          = 4'b0000;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOutput("nowd_edge_clear", grant, 0);
    checkOutput("nowd_ovr_sat", oOverrunCnt, model_ovr);
    finishFrame();
`endif

    // Asynchronous reset in the middle of a grant
    applyStimulus(4'b1111);
    tick();
    checkOutput("mid_grant", grant, 4'b0010);
    #2;
    iRST_n = 1'b0;
    #1;
    checkOutput("mid_rst_grant", grant, 0);
    checkOutput("mid_rst_busy", oBusy, 0);
    checkOutput("mid_rst_fdone", oFrameDone, 0);
    checkOutput("mid_rst_tmo", oTimeout, 0);
    checkOutput("mid_rst_ovr", oOverrunCnt, 0);
    req = 4'b0000;
    tick();
    iRST_n    = 1'b1;
    model_sp  = 0;
    model_ovr = 0;
    tick();
    runFrame(4'b0000, 4'b0000, 4'b0000);
    checkOutput("post_rst_ovr", oOverrunCnt, model_ovr);
    runFrame(4'b0101, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
